sram_bus_arbiter: RTL and testbench
===================================

// Module: sram_bus_arbiter
// PURPOSE
//   Shares one sram-like memory port between the instruction-fetch requester (I) and the
//   EXE-stage data requester (D). Picks a winner each cycle, holds the grant until the address
//   handshake, records the owner of every accepted request in an in-order tag FIFO, and routes
//   each returned data_ok/rdata back to its owner. Sits between the pipeline and the memory bridge.
// PARAMETERS
//   MAX_OUT     4   max accepted-but-unreturned requests (tag FIFO depth, 1..8)
//   STARVE_LIM  8   consecutive D grants while I waits before I is forced in once (1..15)
// PORTS
//   clk          in   1   clock
//   resetn       in   1   synchronous, active-low reset
//   i_req/d_req  in   1   requester valid; held with its fields stable until *_addr_ok
//   i_wr/d_wr    in   1   1 = write
//   i_size/d_size in  2   0=byte 1=half 2=word
//   i_wstrb/d_wstrb in 4  byte enables (writes)
//   i_addr/d_addr in  32  byte address
//   i_wdata/d_wdata in 32 write data
//   i_addr_ok/d_addr_ok out 1  request accepted this cycle
//   i_data_ok/d_data_ok out 1  response for that requester this cycle
//   i_rdata/d_rdata out 32 read data (valid with *_data_ok)
//   m_req,m_wr,m_size,m_wstrb,m_addr,m_wdata out  1/1/2/4/32/32  muxed request to memory
//   m_addr_ok    in   1   memory accepted m_req
//   m_data_ok    in   1   memory response, strictly in acceptance order
//   m_rdata      in   32  memory read data
//   outstanding  out  4   current tag FIFO occupancy
//   arb_err      out  1   sticky: m_data_ok seen with empty tag FIFO
// BEHAVIOUR
// - Reset: all outputs 0; tag FIFO empty; lock clear; starve counter 0; arb_err 0.
// - Winner (combinational, when lock clear): D if d_req and not forced; else I if i_req.
//   Forced = starve_cnt == STARVE_LIM and i_req.
// - m_req = winner valid & (outstanding < MAX_OUT). Full FIFO -> m_req 0, no addr_ok,
//   even if m_data_ok pops this cycle (no bypass; avoids data_ok->req path).
// - m_* fields muxed from the granted requester; *_addr_ok = m_addr_ok & m_req & grant==that.
// - Lock: m_req=1 & m_addr_ok=0 -> lock set, grant frozen to same owner next cycle (sram-like
//   protocol forbids changing a pending request). Cleared on the m_addr_ok cycle.
// - Address handshake (m_req & m_addr_ok): push owner bit (0=I,1=D) at FIFO tail.
// - Response: m_data_ok with FIFO non-empty -> pop head; head owner gets *_data_ok=1 and
//   *_rdata=m_rdata same cycle (zero latency). Other requester data_ok = 0; rdata of the
//   non-owner driven 0. Empty FIFO -> nothing routed, arb_err set until reset.
// - Simultaneous push and pop: both performed; occupancy unchanged; pointers wrap mod MAX_OUT.
//   Push and pop of the same entry impossible (push needs space pre-pop).
// - Write responses routed the same as reads (data_ok with don't-care rdata).
// - Starve counter: +1 on each D handshake while i_req=1 (saturate at STARVE_LIM);
//   reset to 0 on any I handshake or when i_req=0.
// - Throughput: one handshake per cycle max; back-to-back grants allowed.
// - Reset mid-transaction: FIFO and lock cleared; later m_data_ok for pre-reset requests count
//   as arb_err (memory side must be reset together).
// TESTING
// 1. Reset, i_req=1 addr 0x1C000000 read, m_addr_ok=1 -> i_addr_ok cycle 0, outstanding=1;
//    m_data_ok with m_rdata=0x02800000 -> i_data_ok=1, i_rdata=0x02800000, outstanding=0.
// 2. i_req and d_req together, m_addr_ok=1 -> d_addr_ok first, i_addr_ok next cycle; two
//    data_ok return in order D then I with distinct rdata routed correctly.
// 3. i_req alone, m_addr_ok=0 for 3 cycles, d_req rises cycle 1 -> m_addr stays I's address
//    until accept; D granted after.
// 4. MAX_OUT=4: 4 accepted, no data_ok -> m_req=0, outstanding=4; one m_data_ok -> next cycle
//    m_req=1 again.
// 5. d_req held continuously, i_req=1, m_addr_ok=1 -> after 8 D grants the 9th handshake is I.
// 6. m_data_ok with empty FIFO -> no *_data_ok, arb_err=1 held; resetn=0 one cycle -> arb_err=0.

Source files
------------

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter
//   Shares one sram-like memory port between the instruction-fetch requester (I)
//   and the EXE-stage data requester (D). It picks a winner each cycle and holds
//   the grant until the address handshake completes. The owner of every accepted
//   request is recorded in an in-order tag FIFO. Each returned data_ok/rdata is
//   routed back to the requester that issued it.
//
// Handshake semantics (both sides):
//   A requester raises *_req and holds it, with all of its fields stable, until
//   the cycle in which *_addr_ok is 1. That cycle is the address handshake.
//   Responses (*_data_ok) carry no ready and come back strictly in acceptance
//   order.
//
// Ports
//   clk, resetn                    clock, synchronous active-low reset
//   i_* / d_* (req,wr,size,wstrb,addr,wdata)   requester side, inputs
//   i_/d_addr_ok, i_/d_data_ok, i_/d_rdata     requester side, outputs
//   m_req,m_wr,m_size,m_wstrb,m_addr,m_wdata   muxed request to memory
//   m_addr_ok, m_data_ok, m_rdata              memory side, inputs
//   outstanding                    current tag FIFO occupancy
//   arb_err                        sticky: m_data_ok seen with an empty tag FIFO
module sram_bus_arbiter #(
  parameter int MAX_OUT    = 4,
  parameter int STARVE_LIM = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_req,
  input  logic        i_wr,
  input  logic [1:0]  i_size,
  input  logic [3:0]  i_wstrb,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [1:0]  d_size,
  input  logic [3:0]  d_wstrb,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata,
  output logic [3:0]  outstanding,
  output logic        arb_err
);

  // Owner tags: 0 = I, 1 = D. The storage is sized for the largest legal depth,
  // so the 3-bit pointers index it exactly.
  logic [7:0] r_tag;
  logic [2:0] r_wptr;
  logic [2:0] r_rptr;
  logic [3:0] r_count;
  logic       r_lock;
  logic       r_lock_d;
  logic [3:0] r_starve;
  logic       r_arb_err;

  logic w_forced;
  logic w_grant_d;
  logic w_win_valid;
  logic w_hs;
  logic w_pop;
  logic w_head;

  always_comb begin
    w_forced    = (r_starve == 4'(STARVE_LIM)) & i_req;
    w_grant_d   = 1'b0;
    w_win_valid = 1'b0;
    if (r_lock) begin
      // A pending request must not change owner until it is accepted.
      w_grant_d   = r_lock_d;
      w_win_valid = r_lock_d ? d_req : i_req;
    end else begin
      w_grant_d   = d_req & ~w_forced;
      w_win_valid = d_req | i_req;
    end
  end

  // A full FIFO blocks new requests even when a pop happens in the same cycle.
  // This keeps m_data_ok out of the m_req path.
  assign m_req   = resetn & w_win_valid & (r_count < 4'(MAX_OUT));
  assign m_wr    = w_grant_d ? d_wr    : i_wr;
  assign m_size  = w_grant_d ? d_size  : i_size;
  assign m_wstrb = w_grant_d ? d_wstrb : i_wstrb;
  assign m_addr  = w_grant_d ? d_addr  : i_addr;
  assign m_wdata = w_grant_d ? d_wdata : i_wdata;

  assign w_hs      = m_req & m_addr_ok;
  assign i_addr_ok = w_hs & ~w_grant_d;
  assign d_addr_ok = w_hs & w_grant_d;

  assign w_pop     = resetn & m_data_ok & (r_count != 4'd0);
  assign w_head    = r_tag[r_rptr];
  assign i_data_ok = w_pop & ~w_head;
  assign d_data_ok = w_pop & w_head;
  assign i_rdata   = i_data_ok ? m_rdata : 32'd0;
  assign d_rdata   = d_data_ok ? m_rdata : 32'd0;

  assign outstanding = r_count;
  assign arb_err     = r_arb_err;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_tag     <= 8'd0;
      r_wptr    <= 3'd0;
      r_rptr    <= 3'd0;
      r_count   <= 4'd0;
      r_lock    <= 1'b0;
      r_lock_d  <= 1'b0;
      r_starve  <= 4'd0;
      r_arb_err <= 1'b0;
    end else begin
      if (m_req && !m_addr_ok) begin
        r_lock   <= 1'b1;
        r_lock_d <= w_grant_d;
      end else if (w_hs) begin
        r_lock <= 1'b0;
      end

      if (w_hs) begin
        r_tag[r_wptr] <= w_grant_d;
        r_wptr <= (r_wptr == 3'(MAX_OUT - 1)) ? 3'd0 : r_wptr + 3'd1;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == 3'(MAX_OUT - 1)) ? 3'd0 : r_rptr + 3'd1;
      end
      case ({w_hs, w_pop})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase

      if (m_data_ok && (r_count == 4'd0)) begin
        r_arb_err <= 1'b1;
      end

      // The counter counts D wins that happen while I is waiting.
      if (!i_req || i_addr_ok) begin
        r_starve <= 4'd0;
      end else if (d_addr_ok && (r_starve < 4'(STARVE_LIM))) begin
        r_starve <= r_starve + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed testbench for sram_bus_arbiter (MAX_OUT=4, STARVE_LIM=8).
// Inputs change 1 ns after the rising edge. Outputs are checked 2 ns after the
// rising edge.
module tb_sram_bus_arbiter;

  logic        clk;
  logic        resetn;
  logic        i_req, i_wr, d_req, d_wr;
  logic [1:0]  i_size, d_size;
  logic [3:0]  i_wstrb, d_wstrb;
  logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
  logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
  logic [31:0] i_rdata, d_rdata;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata;
  logic        m_addr_ok, m_data_ok;
  logic [31:0] m_rdata;
  logic [3:0]  outstanding;
  logic        arb_err;

  int checks;
  int failures;

  sram_bus_arbiter #(.MAX_OUT(4), .STARVE_LIM(8)) dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_wstrb(i_wstrb),
    .i_addr(i_addr), .i_wdata(i_wdata),
    .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_wstrb(d_wstrb),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .outstanding(outstanding), .arb_err(arb_err)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advances to 1 ns after the next rising edge. Inputs are driven from this point.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Lets combinational outputs settle before they are checked.
  task automatic settle();
    #1;
  endtask

  initial begin
    checks = 0; failures = 0;
    resetn = 1'b0;
    i_req = 0; i_wr = 0; i_size = 2'd2; i_wstrb = 4'h0; i_addr = 0; i_wdata = 0;
    d_req = 0; d_wr = 0; d_size = 2'd2; d_wstrb = 4'h0; d_addr = 0; d_wdata = 0;
    m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;

    // ---- reset state ----
    next_cycle();
    next_cycle();
    settle();
    chk("rst_outstanding", 32'(outstanding), 32'd0);
    chk("rst_arb_err", 32'(arb_err), 32'd0);
    chk("rst_m_req", 32'(m_req), 32'd0);
    chk("rst_i_addr_ok", 32'(i_addr_ok), 32'd0);
    resetn = 1'b1;

    // ---- 1: single I read ----
    next_cycle();
    i_req = 1; i_addr = 32'h1C00_0000; m_addr_ok = 1;
    settle();
    chk("t1_m_req", 32'(m_req), 32'd1);
    chk("t1_m_addr", m_addr, 32'h1C00_0000);
    chk("t1_i_addr_ok", 32'(i_addr_ok), 32'd1);
    chk("t1_d_addr_ok", 32'(d_addr_ok), 32'd0);
    next_cycle();
    i_req = 0; m_addr_ok = 0;
    settle();
    chk("t1_outstanding1", 32'(outstanding), 32'd1);
    chk("t1_m_req_idle", 32'(m_req), 32'd0);
    m_data_ok = 1; m_rdata = 32'h0280_0000;
    settle();
    chk("t1_i_data_ok", 32'(i_data_ok), 32'd1);
    chk("t1_i_rdata", i_rdata, 32'h0280_0000);
    chk("t1_d_data_ok", 32'(d_data_ok), 32'd0);
    chk("t1_d_rdata", d_rdata, 32'd0);
    next_cycle();
    m_data_ok = 0;
    settle();
    chk("t1_outstanding0", 32'(outstanding), 32'd0);

    // ---- 2: I and D together, D wins first ----
    i_req = 1; i_addr = 32'h0000_1000; d_req = 1; d_addr = 32'h0000_2000; m_addr_ok = 1;
    settle();
    chk("t2_d_addr_ok", 32'(d_addr_ok), 32'd1);
    chk("t2_i_addr_ok0", 32'(i_addr_ok), 32'd0);
    chk("t2_m_addr_d", m_addr, 32'h0000_2000);
    next_cycle();
    d_req = 0;
    settle();
    chk("t2_i_addr_ok1", 32'(i_addr_ok), 32'd1);
    chk("t2_m_addr_i", m_addr, 32'h0000_1000);
    chk("t2_outstanding1", 32'(outstanding), 32'd1);
    next_cycle();
    i_req = 0; m_addr_ok = 0;
    settle();
    chk("t2_outstanding2", 32'(outstanding), 32'd2);
    m_data_ok = 1; m_rdata = 32'h1111_1111;
    settle();
    chk("t2_resp1_d_ok", 32'(d_data_ok), 32'd1);
    chk("t2_resp1_d_rdata", d_rdata, 32'h1111_1111);
    chk("t2_resp1_i_ok", 32'(i_data_ok), 32'd0);
    chk("t2_resp1_i_rdata", i_rdata, 32'd0);
    next_cycle();
    m_rdata = 32'h2222_2222;
    settle();
    chk("t2_resp2_i_ok", 32'(i_data_ok), 32'd1);
    chk("t2_resp2_i_rdata", i_rdata, 32'h2222_2222);
    chk("t2_resp2_d_ok", 32'(d_data_ok), 32'd0);
    next_cycle();
    m_data_ok = 0;
    settle();
    chk("t2_outstanding0", 32'(outstanding), 32'd0);

    // ---- 3: lock holds I's pending request while D arrives ----
    i_req = 1; i_addr = 32'h0000_3000; m_addr_ok = 0;
    settle();
    chk("t3_c0_m_addr", m_addr, 32'h0000_3000);
    chk("t3_c0_i_addr_ok", 32'(i_addr_ok), 32'd0);
    next_cycle();
    d_req = 1; d_addr = 32'h0000_4000;
    settle();
    chk("t3_c1_m_addr", m_addr, 32'h0000_3000);
    chk("t3_c1_d_addr_ok", 32'(d_addr_ok), 32'd0);
    next_cycle();
    settle();
    chk("t3_c2_m_addr", m_addr, 32'h0000_3000);
    chk("t3_c2_m_req", 32'(m_req), 32'd1);
    next_cycle();
    m_addr_ok = 1;
    settle();
    chk("t3_c3_i_addr_ok", 32'(i_addr_ok), 32'd1);
    chk("t3_c3_m_addr", m_addr, 32'h0000_3000);
    next_cycle();
    i_req = 0;
    settle();
    chk("t3_c4_d_addr_ok", 32'(d_addr_ok), 32'd1);
    chk("t3_c4_m_addr", m_addr, 32'h0000_4000);
    next_cycle();
    d_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'hAAAA_0001;
    settle();
    chk("t3_outstanding2", 32'(outstanding), 32'd2);
    chk("t3_resp1_i_ok", 32'(i_data_ok), 32'd1);
    next_cycle();
    m_rdata = 32'hAAAA_0002;
    settle();
    chk("t3_resp2_d_ok", 32'(d_data_ok), 32'd1);
    chk("t3_resp2_d_rdata", d_rdata, 32'hAAAA_0002);
    next_cycle();
    m_data_ok = 0;
    settle();
    chk("t3_outstanding0", 32'(outstanding), 32'd0);

    // ---- 4: full FIFO blocks m_req, no bypass on a same-cycle pop ----
    d_req = 1; d_wr = 1; d_wstrb = 4'hF; d_addr = 32'h0000_5000; m_addr_ok = 1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("t4_fill_d_addr_ok", 32'(d_addr_ok), 32'd1);
      next_cycle();
    end
    settle();
    chk("t4_full_outstanding", 32'(outstanding), 32'd4);
    chk("t4_full_m_req", 32'(m_req), 32'd0);
    chk("t4_full_d_addr_ok", 32'(d_addr_ok), 32'd0);
    m_data_ok = 1;
    settle();
    chk("t4_pop_m_req_nobypass", 32'(m_req), 32'd0);
    chk("t4_pop_d_data_ok", 32'(d_data_ok), 32'd1);
    next_cycle();
    m_data_ok = 0;
    settle();
    chk("t4_after_pop_outstanding", 32'(outstanding), 32'd3);
    chk("t4_after_pop_m_req", 32'(m_req), 32'd1);
    chk("t4_after_pop_d_addr_ok", 32'(d_addr_ok), 32'd1);
    next_cycle();
    d_req = 0; d_wr = 0; m_addr_ok = 0; m_data_ok = 1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("t4_drain_d_data_ok", 32'(d_data_ok), 32'd1);
      next_cycle();
    end
    m_data_ok = 0;
    settle();
    chk("t4_drained_outstanding", 32'(outstanding), 32'd0);

    // ---- 5: starvation, the 9th handshake goes to I ----
    d_req = 1; d_addr = 32'h0000_6000; i_req = 1; i_addr = 32'h0000_7000; m_addr_ok = 1;
    settle();
    chk("t5_c0_d_addr_ok", 32'(d_addr_ok), 32'd1);
    for (int k = 1; k < 8; k++) begin
      next_cycle();
      m_data_ok = 1;
      settle();
      chk("t5_d_grant", 32'(d_addr_ok), 32'd1);
      chk("t5_i_waiting", 32'(i_addr_ok), 32'd0);
    end
    next_cycle();
    settle();
    chk("t5_c8_i_addr_ok", 32'(i_addr_ok), 32'd1);
    chk("t5_c8_d_addr_ok", 32'(d_addr_ok), 32'd0);
    chk("t5_c8_m_addr", m_addr, 32'h0000_7000);
    chk("t5_c8_d_data_ok", 32'(d_data_ok), 32'd1);
    next_cycle();
    i_req = 0;
    settle();
    chk("t5_c9_d_addr_ok", 32'(d_addr_ok), 32'd1);
    chk("t5_c9_i_data_ok", 32'(i_data_ok), 32'd1);
    next_cycle();
    d_req = 0; m_addr_ok = 0;
    settle();
    chk("t5_c10_d_data_ok", 32'(d_data_ok), 32'd1);
    next_cycle();
    m_data_ok = 0;
    settle();
    chk("t5_outstanding0", 32'(outstanding), 32'd0);
    chk("t5_arb_err0", 32'(arb_err), 32'd0);

    // ---- 6: stray m_data_ok sets a sticky error; reset clears it ----
    m_data_ok = 1; m_rdata = 32'hDEAD_BEEF;
    settle();
    chk("t6_i_data_ok", 32'(i_data_ok), 32'd0);
    chk("t6_d_data_ok", 32'(d_data_ok), 32'd0);
    next_cycle();
    m_data_ok = 0;
    settle();
    chk("t6_arb_err_set", 32'(arb_err), 32'd1);
    next_cycle();
    settle();
    chk("t6_arb_err_held", 32'(arb_err), 32'd1);
    resetn = 0;
    next_cycle();
    resetn = 1;
    settle();
    chk("t6_arb_err_cleared", 32'(arb_err), 32'd0);
    chk("t6_outstanding", 32'(outstanding), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
